// File: rtl/pulse_debounce.sv
// Debouncer for a raw, possibly asynchronous level. The input is synchronized first,
// then q follows only after DEBOUNCE_CYC consecutive samples agree on the new level.
module pulse_debounce #(
    parameter int DEBOUNCE_CYC = 4,
    parameter int CNT_W        = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall,
    output logic busy
);

    typedef enum logic [1:0] {
        LOW    = 2'd0,
        CHK_HI = 2'd1,
        HIGH   = 2'd2,
        CHK_LO = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s1_q;
    logic             s2_q;
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             deb_q;
    logic             rise_q;
    logic             fall_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    // An aborted qualification always falls back to the stable state with cnt=0,
    // so a later attempt restarts from 1 and partial counts never accumulate.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= LOW;
            cnt_q   <= '0;
            deb_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            case (state_q)
                LOW: begin
                    if (s2_q) begin
                        state_q <= CHK_HI;
                        cnt_q   <= CNT_ONE;
                    end else begin
                        cnt_q <= '0;
                    end
                end
                CHK_HI: begin
                    if (!s2_q) begin
                        state_q <= LOW;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= HIGH;
                        cnt_q   <= '0;
                        deb_q   <= 1'b1;
                        rise_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                HIGH: begin
                    if (!s2_q) begin
                        state_q <= CHK_LO;
                        cnt_q   <= CNT_ONE;
                    end else begin
                        cnt_q <= '0;
                    end
                end
                CHK_LO: begin
                    if (s2_q) begin
                        state_q <= HIGH;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= LOW;
                        cnt_q   <= '0;
                        deb_q   <= 1'b0;
                        fall_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= LOW;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign q    = deb_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign busy = (state_q == CHK_HI) || (state_q == CHK_LO);

endmodule

// File: tb/tb_pulse_debounce.sv
// Directed bench for pulse_debounce (DEBOUNCE_CYC=4): a vector table of per-edge
// inputs/expected outputs, plus hand sequences for asynchronous reset mid-cycle.
module tb_pulse_debounce;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic d = 1'b0;
    logic q, rise, fall, busy;

    int n_checks = 0;
    int n_pass   = 0;

    pulse_debounce #(.DEBOUNCE_CYC(4), .CNT_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .d(d),
        .q(q), .rise(rise), .fall(fall), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       din;
        logic [3:0] exp;   // {q, rise, fall, busy}
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic dv, input logic [3:0] e);
        vec_t v;
        v.rst_n = r;
        v.din   = dv;
        v.exp   = e;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [3:0] exp);
        logic [3:0] got;
        got = {q, rise, fall, busy};
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("%s: q/rise/fall/busy=%b ok", name, got);
        end else begin
            $display("FAIL %s: q/rise/fall/busy got %b want %b", name, got, exp);
        end
    endtask

    // Drive between edges, then sample 1 ns after the rising edge.
    task automatic step(input string name, input logic r, input logic dv, input logic [3:0] e);
        @(negedge clk);
        reset_n = r;
        d       = dv;
        @(posedge clk);
        #1;
        check(name, e);
    endtask

    initial begin
        // Reset held, d toggling: everything stays low
        add(0, 0, 4'b0000); add(0, 1, 4'b0000); add(0, 1, 4'b0000);
        add(0, 0, 4'b0000); add(0, 1, 4'b0000);
        // Release with d=1: busy from edge 3, rise at edge 6
        add(1, 1, 4'b0000); add(1, 1, 4'b0000); add(1, 1, 4'b0001);
        add(1, 1, 4'b0001); add(1, 1, 4'b0001); add(1, 1, 4'b1100);
        add(1, 1, 4'b1000); add(1, 1, 4'b1000);
        // d=0 stable from q=1: fall at edge 6
        add(1, 0, 4'b1000); add(1, 0, 4'b1000); add(1, 0, 4'b1001);
        add(1, 0, 4'b1001); add(1, 0, 4'b1001); add(1, 0, 4'b0010);
        add(1, 0, 4'b0000); add(1, 0, 4'b0000);
        // Two-edge glitch: busy pulses, no rise
        add(1, 1, 4'b0000); add(1, 1, 4'b0000); add(1, 0, 4'b0001);
        add(1, 0, 4'b0001); add(1, 0, 4'b0000); add(1, 0, 4'b0000);
        // d toggling every 3 edges: qualification restarts and never completes
        add(1, 1, 4'b0000); add(1, 1, 4'b0000); add(1, 1, 4'b0001);
        add(1, 0, 4'b0001); add(1, 0, 4'b0001); add(1, 0, 4'b0000);
        add(1, 1, 4'b0000); add(1, 1, 4'b0000); add(1, 1, 4'b0001);
        add(1, 0, 4'b0001); add(1, 0, 4'b0001); add(1, 0, 4'b0000);
        add(1, 0, 4'b0000); add(1, 0, 4'b0000);

        reset_n = 1'b0;
        d       = 1'b0;
        #1;
        check("reset_init", 4'b0000);

        for (int i = 0; i < vecs.size(); i++)
            step($sformatf("vec%0d", i), vecs[i].rst_n, vecs[i].din, vecs[i].exp);

        // Async reset while in CHK_HI with cnt=2
        step("mid_e1", 1, 1, 4'b0000);
        step("mid_e2", 1, 1, 4'b0000);
        step("mid_e3", 1, 1, 4'b0001);
        step("mid_e4", 1, 1, 4'b0001);
        #2 reset_n = 1'b0;
        #1 check("mid_async_rst", 4'b0000);
        step("mid_rst_held", 0, 1, 4'b0000);
        step("rel_e1", 1, 1, 4'b0000);
        step("rel_e2", 1, 1, 4'b0000);
        step("rel_e3", 1, 1, 4'b0001);
        step("rel_e4", 1, 1, 4'b0001);
        step("rel_e5", 1, 1, 4'b0001);
        step("rel_e6", 1, 1, 4'b1100);
        step("rel_e7", 1, 1, 4'b1000);

        // Async reset from q=1 clears q without a clock edge
        #2 reset_n = 1'b0;
        #1 check("high_async_rst", 4'b0000);
        step("high_rst_held", 0, 1, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pulse_debounce.md
PULSE_DEBOUNCE -- requirements
Module: pulse_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 4: consecutive synchronized samples of a new level required before q changes; legal range 2..(2^CNT_W).
REQ-002 Parameter CNT_W, default 4: width of the internal stability counter.
REQ-003 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 Port d, input, 1: raw, possibly asynchronous and bouncing input level.
REQ-006 Port q, output, 1: debounced level, registered.
REQ-007 Port rise, output, 1: registered one-cycle pulse when q goes 0->1.
REQ-008 Port fall, output, 1: registered one-cycle pulse when q goes 1->0.
REQ-009 Port busy, output, 1: high while a level change is being qualified (state CHK_HI or CHK_LO).

Function
REQ-010 d SHALL pass through a two-flop synchronizer (s1 <= d; s2 <= s1); the FSM SHALL use only s2.
REQ-011 FSM states SHALL be LOW, CHK_HI, HIGH, CHK_LO.
REQ-012 LOW: s2=1 -> CHK_HI with cnt=1; else stay, cnt=0.
REQ-013 CHK_HI: s2=0 -> LOW, cnt=0, no pulse; s2=1 and cnt=DEBOUNCE_CYC-1 -> HIGH, q<=1, rise<=1, cnt=0; s2=1 otherwise -> cnt+1.
REQ-014 HIGH: s2=0 -> CHK_LO with cnt=1; else stay, cnt=0.
REQ-015 CHK_LO: mirror of CHK_HI (s2=1 aborts to HIGH; completion -> LOW, q<=0, fall<=1).
REQ-016 Latency: counting the first clk edge that samples a new stable d as edge 1, q and the rise/fall pulse SHALL update on edge DEBOUNCE_CYC+2.
REQ-017 rise and fall SHALL each be high for exactly one clk cycle per q transition and never simultaneously.
REQ-018 Any interruption of the new level before qualification SHALL restart qualification from cnt=1 on the next change; partial counts SHALL NOT accumulate.
REQ-019 busy SHALL be decoded from the state register only (high in CHK_HI/CHK_LO), no dependence on d.
REQ-020 cnt SHALL never exceed DEBOUNCE_CYC-1 and SHALL NOT wrap.
REQ-021 q SHALL change only on state transitions CHK_HI->HIGH and CHK_LO->LOW.

Reset
REQ-022 reset_n=0 SHALL immediately, without a clock edge, force s1=s2=0, state=LOW, cnt=0, q=0, rise=0, fall=0, busy=0.
REQ-023 Reset asserted mid-qualification SHALL discard the partial count; no pulse SHALL be emitted.
REQ-024 After reset_n rises with d held 1, q SHALL rise per REQ-016 with one rise pulse.

Verification (DEBOUNCE_CYC=4, 10 ns clock)
REQ-025 Hold reset_n=0, toggle d -> q=rise=fall=busy=0 at all times.
REQ-026 Release reset, d=1 stable -> busy high from edge 3, q 0->1 and rise=1 for one cycle at edge 6, busy=0 after edge 6.
REQ-027 Glitch: d=1 for 2 edges then 0 -> q stays 0, rise never asserts, busy pulses then returns 0.
REQ-028 From q=1, d=0 stable -> fall=1 for one cycle with q 1->0 at edge 6; rise stays 0.
REQ-029 d toggling every 3 edges -> q never changes, no rise/fall pulses.
REQ-030 Assert reset_n=0 between clock edges while in CHK_HI at cnt=2 -> all outputs 0 before the next edge; after release with d=1, rise occurs at edge 6 counted from release.
